// File: rtl/wb_cmd_master.sv
// ============================================================================
//  Module      : wb_cmd_master
//  Description : Command-FIFO-fed Wishbone classic master, one cycle at a
//                time, with ack timeout and a registered response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [3:0]  cmd_sel,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_we,
   output logic        busy
);

   localparam int         AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } cmd_t;

   cmd_t          fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   state_t        state_q, state_d;
   logic [7:0]    tmo_q, tmo_d;
   cmd_t          bus_q, bus_d;
   logic          cyc_q, cyc_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_dat_q, rsp_dat_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_we_q, rsp_we_d;
   logic          push, pop;

   assign cmd_ready = (count_q != FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);

   // Read data is zeroed on entry so the bus never carries stale write data.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {cmd_we, cmd_sel, cmd_adr, (cmd_we ? cmd_dat : 32'h0)};
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         bus_q       <= '0;
         cyc_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         bus_q       <= bus_d;
         cyc_q       <= cyc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         rsp_we_q    <= rsp_we_d;
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      tmo_d       = tmo_q;
      bus_d       = bus_q;
      cyc_d       = cyc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      rsp_we_d    = rsp_we_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               bus_d   = fifo_q[rd_ptr_q];
               cyc_d   = 1'b1;
               tmo_d   = '0;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = bus_q.we ? 32'h0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_we_d    = bus_q.we;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (tmo_q == TMO_LIMIT) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
               rsp_we_d    = bus_q.we;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = bus_q.we;
   assign wbm_sel_o = bus_q.sel;
   assign wbm_adr_o = bus_q.adr;
   assign wbm_dat_o = bus_q.dat;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_we    = rsp_we_q;
   assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
//  Module      : tb_wb_cmd_master
//  Description : Directed bench for wb_cmd_master with a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;

   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 8;
   localparam int P_IDLE = 0, P_BUS = 1, P_RESP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic        cmd_we = 1'b0;
   logic [3:0]  cmd_sel = '0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_dat_i = '0;
   logic        rsp_valid, rsp_ready = 1'b1;
   logic [31:0] rsp_dat;
   logic        rsp_err, rsp_we, busy;

   wb_cmd_master #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dat(rsp_dat), .rsp_err(rsp_err), .rsp_we(rsp_we), .busy(busy)
   );

   always #5 clk = ~clk;

   // Command record: payload plus how the bench slave will answer it.
   typedef struct {
      bit          we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      int          ack_at;   // 1-based bus edge carrying ack; 0 = never
      logic [31:0] rdat;
   } cmd_t;

   cmd_t cmds [64];
   int   n_cmds = 0;
   int   tb_idx = 0;

   int   n_cmp = 0, n_err = 0;

   // Transaction-level model.
   int          m_fifo [$];
   int          m_phase = P_IDLE;
   int          m_cur = 0, m_edges = 0, n_rsp = 0;
   bit          m_acc = 1'b0, m_push = 1'b0;
   bit          m_rsp_valid = 1'b0, m_rsp_err = 1'b0, m_rsp_we = 1'b0;
   logic [31:0] m_rsp_dat = '0;

   bit          stray_ack = 1'b0;
   int          cyc_run = 0, last_cyc_len = 0, rsp_seen = 0;
   logic [31:0] last_rsp_dat = '0;
   logic        last_rsp_err = 1'b0, last_rsp_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fifo.delete();
         m_phase     = P_IDLE;
         m_edges     = 0;
         m_acc       = 1'b0;
         m_rsp_valid = 1'b0;
         m_rsp_dat   = '0;
         m_rsp_err   = 1'b0;
         m_rsp_we    = 1'b0;
      end else begin
         m_push = cmd_valid && (m_fifo.size() < FIFO_DEPTH);
         m_acc  = m_push;
         case (m_phase)
            P_IDLE: if (m_fifo.size() > 0) begin
               m_cur   = m_fifo.pop_front();
               m_edges = 0;
               m_phase = P_BUS;
            end
            P_BUS: if (wbm_ack_i) begin
               m_rsp_dat   = cmds[m_cur].we ? 32'h0 : wbm_dat_i;
               m_rsp_err   = 1'b0;
               m_rsp_we    = cmds[m_cur].we;
               m_rsp_valid = 1'b1;
               m_phase     = P_RESP;
            end else if (m_edges == TIMEOUT) begin
               m_rsp_dat   = 32'h0;
               m_rsp_err   = 1'b1;
               m_rsp_we    = cmds[m_cur].we;
               m_rsp_valid = 1'b1;
               m_phase     = P_RESP;
            end else begin
               m_edges++;
            end
            default: if (rsp_ready) begin
               m_rsp_valid = 1'b0;
               m_phase     = P_IDLE;
               n_rsp++;
            end
         endcase
         if (m_push) m_fifo.push_back(tb_idx);
      end
   end

   // Bench slave answers on the bus edge its command asks for.
   always @(negedge clk) begin
      wbm_ack_i = stray_ack ||
                  (m_phase == P_BUS && cmds[m_cur].ack_at != 0 && cmds[m_cur].ack_at == m_edges + 1);
      wbm_dat_i = (m_phase == P_BUS) ? cmds[m_cur].rdat : 32'hBAD0_BAD0;
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
         chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         cyc_run = 0;
      end else begin
         chk("cyc", 32'(wbm_cyc_o), 32'(m_phase == P_BUS));
         chk("stb", 32'(wbm_stb_o), 32'(m_phase == P_BUS));
         if (m_phase == P_BUS) begin
            chk("we", 32'(wbm_we_o), 32'(cmds[m_cur].we));
            chk("sel", 32'(wbm_sel_o), 32'(cmds[m_cur].sel));
            chk("adr", wbm_adr_o, cmds[m_cur].adr);
            chk("dat_o", wbm_dat_o, cmds[m_cur].we ? cmds[m_cur].dat : 32'h0);
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
         if (m_rsp_valid) begin
            chk("rsp_dat", rsp_dat, m_rsp_dat);
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
            chk("rsp_we", 32'(rsp_we), 32'(m_rsp_we));
         end
         chk("busy", 32'(busy), 32'(m_fifo.size() != 0 || m_phase != P_IDLE));
         chk("cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < FIFO_DEPTH));
         if (rsp_valid) begin
            rsp_seen++;
            last_rsp_dat = rsp_dat;
            last_rsp_err = rsp_err;
            last_rsp_we  = rsp_we;
         end
         if (wbm_cyc_o) cyc_run++;
         else if (cyc_run > 0) begin
            last_cyc_len = cyc_run;
            cyc_run      = 0;
         end
      end
   end

   task automatic push(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input int ack_at, input logic [31:0] rdat);
      bit ok = 1'b0;
      cmds[n_cmds] = '{we, sel, adr, dat, ack_at, rdat};
      tb_idx    = n_cmds;
      n_cmds++;
      cmd_we    = we;
      cmd_sel   = sel;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_acc) begin
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL push_accept: command %0d not accepted within 200 cycles", tb_idx);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (m_phase == P_IDLE && m_fifo.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL wait_idle: model not idle within 300 cycles");
      end
   endtask

   initial begin
      int rsp_base;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single write, ack on 2nd bus edge; also pins one-edge issue latency.
      push(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 2, 32'h0);
      chk("lat_edge_n", 32'(wbm_cyc_o), 32'd0);
      @(negedge clk);
      chk("lat_edge_n1", 32'(wbm_cyc_o), 32'd1);
      chk("wr_adr_lit", wbm_adr_o, 32'h3000_0004);
      chk("wr_dat_lit", wbm_dat_o, 32'hDEAD_BEEF);
      wait_idle();
      chk("wr_cyc_len", 32'(last_cyc_len), 32'd2);
      chk("wr_rsp_dat", last_rsp_dat, 32'h0);
      chk("wr_rsp_err", 32'(last_rsp_err), 32'd0);
      chk("wr_rsp_we", 32'(last_rsp_we), 32'd1);

      // Single read, ack on first bus edge.
      push(1'b0, 4'h3, 32'h3000_0000, 32'h5555_AAAA, 1, 32'h1234_5678);
      wait_idle();
      chk("rd_cyc_len", 32'(last_cyc_len), 32'd1);
      chk("rd_rsp_dat", last_rsp_dat, 32'h1234_5678);
      chk("rd_rsp_we", 32'(last_rsp_we), 32'd0);

      // Timeout with no ack, then ack exactly on the timeout edge.
      push(1'b0, 4'h1, 32'h3000_0010, 32'h0, 0, 32'hAAAA_5555);
      wait_idle();
      chk("tmo_cyc_len", 32'(last_cyc_len), 32'd9);
      chk("tmo_rsp_err", 32'(last_rsp_err), 32'd1);
      chk("tmo_rsp_dat", last_rsp_dat, 32'h0);
      push(1'b0, 4'h2, 32'h3000_0014, 32'h0, 9, 32'hCAFE_F00D);
      wait_idle();
      chk("tmo_ack_cyc_len", 32'(last_cyc_len), 32'd9);
      chk("tmo_ack_rsp_err", 32'(last_rsp_err), 32'd0);
      chk("tmo_ack_rsp_dat", last_rsp_dat, 32'hCAFE_F00D);

      // Ack while idle must not start anything.
      stray_ack = 1'b1;
      repeat (3) @(negedge clk);
      stray_ack = 1'b0;
      @(negedge clk);
      chk("stray_cyc", 32'(wbm_cyc_o), 32'd0);

      // Fill: one in flight (times out, held in RESP) plus four queued.
      rsp_ready = 1'b0;
      rsp_base  = n_rsp;
      push(1'b1, 4'hF, 32'h4000_0000, 32'h1111_1111, 0, 32'h0);
      push(1'b0, 4'hF, 32'h4000_0004, 32'h0, 1, 32'h2222_2222);
      push(1'b1, 4'hC, 32'h4000_0008, 32'h3333_3333, 3, 32'h0);
      push(1'b0, 4'h8, 32'h4000_000C, 32'h0, 2, 32'h4444_4444);
      push(1'b1, 4'h1, 32'h4000_0010, 32'h5555_5555, 1, 32'h0);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      chk("bp_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_err", 32'(rsp_err), 32'd1);
      rsp_ready = 1'b1;
      wait_idle();
      @(negedge clk);
      chk("full_rsp_count", 32'(n_rsp - rsp_base), 32'd5);

      // Reset while a bus cycle is open with two commands queued.
      push(1'b1, 4'hF, 32'h5000_0000, 32'h0A0A_0A0A, 0, 32'h0);
      push(1'b1, 4'hF, 32'h5000_0004, 32'h0B0B_0B0B, 0, 32'h0);
      push(1'b1, 4'hF, 32'h5000_0008, 32'h0C0C_0C0C, 0, 32'h0);
      chk("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("async_rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_adr", wbm_adr_o, 32'h0);
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      rsp_seen = 0;
      repeat (15) @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_seen), 32'd0);

      // Normal operation resumes on the first edge after reset.
      push(1'b0, 4'h6, 32'h6000_0020, 32'h0, 2, 32'h8765_4321);
      wait_idle();
      chk("post_rst_rd_dat", last_rsp_dat, 32'h8765_4321);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, the number of bus cycles without ack before an abort (1..255).
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-006 SHALL have ports cmd_we (input, 1), cmd_sel (input, 4), cmd_adr (input, 32) and cmd_dat (input, 32): the command payload.
REQ-007 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o (output, 1 each): Wishbone classic master control.
REQ-008 SHALL have ports wbm_sel_o (output, 4), wbm_adr_o (output, 32) and wbm_dat_o (output, 32): Wishbone master payload.
REQ-009 SHALL have ports wbm_ack_i (input, 1) and wbm_dat_i (input, 32): the slave acknowledge and read data.
REQ-010 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): the response handshake.
REQ-011 SHALL have ports rsp_dat (output, 32), rsp_err (output, 1) and rsp_we (output, 1): response read data, timeout flag, and echo of the command type.
REQ-012 SHALL have port busy, output, 1: high while the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-013 SHALL hold cmd_ready = !fifo_full, combinational from FIFO state only, and push a command at every edge where cmd_valid && cmd_ready.
REQ-014 SHALL process commands strictly in FIFO order and SHALL neither drop nor duplicate any command.
REQ-015 SHALL implement FSM states IDLE, BUS and RESP.
REQ-016 In IDLE with the FIFO non-empty at the edge: pop the head, register it onto wbm_*_o, assert wbm_cyc_o = wbm_stb_o = 1, clear the timeout counter, and go to BUS.
REQ-017 On reads, wbm_dat_o SHALL be 0; wbm_sel_o and wbm_adr_o SHALL always come from the command.
REQ-018 Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE SHALL have wbm_cyc_o high after edge N+1.
REQ-019 In BUS, all wbm_*_o SHALL stay stable until the cycle terminates; the timeout counter SHALL increment by 1 at each edge where wbm_ack_i = 0.
REQ-020 On wbm_ack_i = 1 at an edge in BUS: drop cyc/stb after that edge, set rsp_dat = wbm_dat_i for reads (0 for writes), rsp_err = 0, rsp_we = command we, rsp_valid = 1, and go to RESP.
REQ-021 Timeout: when the counter equals TIMEOUT at an edge with wbm_ack_i = 0: drop cyc/stb, set rsp_dat = 0, rsp_err = 1, rsp_valid = 1, and go to RESP.
REQ-022 If wbm_ack_i = 1 on the same edge the counter reaches TIMEOUT, the ack SHALL win: normal completion, rsp_err = 0.
REQ-023 SHALL ignore wbm_ack_i outside BUS.
REQ-024 In RESP, SHALL hold rsp_valid and rsp_* stable until rsp_ready = 1 at an edge, then clear rsp_valid and go to IDLE.
REQ-025 SHALL leave wbm_cyc_o low for at least one full cycle between consecutive transactions, because the FSM always passes through RESP and IDLE.
REQ-026 SHALL perform at most one outstanding bus cycle; no pipelining and no burst.
REQ-027 A simultaneous FIFO push and pop in one cycle SHALL be legal, and the occupancy SHALL then remain unchanged.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count of width log2(FIFO_DEPTH)+1.

Reset
REQ-029 While wb_rst_i is high, asynchronously: state = IDLE, FIFO empty, and wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o = 0.
REQ-030 While wb_rst_i is high, asynchronously: rsp_valid, rsp_dat, rsp_err, rsp_we, busy = 0 and the timeout counter = 0.
REQ-031 While wb_rst_i is high, cmd_ready SHALL read 1.
REQ-032 Reset during BUS SHALL drop cyc/stb immediately and discard the in-flight command and all queued commands; no response is produced for them.
REQ-033 After reset deasserts, the first edge SHALL be treated as a normal IDLE cycle.

Verification
REQ-034 Single write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; ack on 2nd bus cycle -> wbm_* match the command, cyc high for 2 cycles, rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-035 Single read: adr=0x3000_0000; slave acks with dat_i=0x1234_5678 -> rsp_dat=0x1234_5678, rsp_we=0, cyc drops after the ack edge.
REQ-036 FIFO full: push 5 commands with rsp_ready=0 and no ack -> cmd_ready low after 4 queued + 1 in flight; all complete in order once released.
REQ-037 Timeout: TIMEOUT=8, no ack -> cyc high for exactly 9 cycles, rsp_err=1, rsp_dat=0; with ack on the final edge -> rsp_err=0.
REQ-038 Reset mid-BUS: assert wb_rst_i with cyc high and 2 queued -> cyc low without waiting for a clock, busy=0, no rsp_valid afterwards.
REQ-039 Backpressure: rsp_ready=0 for 10 cycles with 2 queued -> rsp_* stable, no new cyc until accepted, then a ≥1-cycle cyc gap.
